// File: rtl/potential_decay_array.sv
// Multi-channel float32 membrane-potential decay engine: one channel per cycle, divide by 2^rate.
// Optional flush counter output enabled by `define POTENTIAL_DECAY_FLUSH_COUNT_EN.
module potential_decay_array #(
    parameter int NUM_CH = 16,
    parameter int ADDR_W = 4,
    parameter int RATE_W = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              timestep,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    input  logic              rate_we,
    input  logic [ADDR_W-1:0] rate_addr,
    input  logic [RATE_W-1:0] rate_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
    ,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]   LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);
    localparam logic [ADDR_W-1:0] LP_LAST   = ADDR_W'(NUM_CH - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic               r_pending;
    logic               r_overrun;
    logic               r_busy;
    logic               r_sweep_done;
    logic [31:0]        r_rd_data;
    logic [31:0]        r_pot  [NUM_CH];
    logic [RATE_W-1:0]  r_rate [NUM_CH];

    logic [31:0]        w_cur_pot;
    logic [RATE_W-1:0]  w_cur_rate;
    logic               w_sweeping;
    logic               w_wr_hit;
    logic               w_rate_hit;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        in_range = ({1'b0, addr} < LP_NUM_CH);
    endfunction

    // Division by 2^r is an exponent subtract; anything that would go denormal flushes to signed zero.
    function automatic logic [31:0] decay_op(input logic [31:0] x, input logic [RATE_W-1:0] r);
        logic [7:0] e;
        logic [7:0] r8;
        e  = x[30:23];
        r8 = 8'(r);
        if (r8 == 8'd0 || e == 8'hFF)
            decay_op = x;
        else if (e <= r8)
            decay_op = {x[31], 31'b0};
        else
            decay_op = {x[31], e - r8, x[22:0]};
    endfunction

    assign w_sweeping = (r_state == ST_SWEEP);
    assign w_cur_pot  = r_pot[r_idx];
    assign w_cur_rate = r_rate[r_idx];
    assign w_wr_hit   = wr_en && (r_state == ST_IDLE) && in_range(wr_addr);
    assign w_rate_hit = rate_we && in_range(rate_addr);

    assign busy       = r_busy;
    assign sweep_done = r_sweep_done;
    assign overrun    = r_overrun;
    assign wr_ready   = ~r_busy;
    assign rd_data    = r_rd_data;

    // NOTE: sequential state uses <= so every block samples pre-edge values regardless of order.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (timestep && r_state != ST_IDLE) begin
                if (r_pending)
                    r_overrun <= 1'b1;
                else
                    r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (timestep || r_pending) begin
                        r_pending <= 1'b0;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LP_LAST) begin
                        r_sweep_done <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the register file is reset explicitly because cleared potentials are architecturally visible.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pot[i]  <= '0;
                r_rate[i] <= RATE_W'(1);
            end
        end else begin
            if (w_wr_hit)
                r_pot[wr_addr] <= wr_data;
            if (w_sweeping)
                r_pot[r_idx] <= decay_op(w_cur_pot, w_cur_rate);
            if (w_rate_hit)
                r_rate[rate_addr] <= rate_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            r_rd_data <= '0;
        else
            r_rd_data <= in_range(rd_addr) ? r_pot[rd_addr] : 32'd0;
    end

`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
    logic [15:0] r_flush_count;
    logic        w_flush;

    // Counts only genuine normals lost to underflow, not zeros or denormals already at zero.
    assign w_flush = w_sweeping && (w_cur_rate != '0) && (w_cur_pot[30:23] != 8'h00) &&
                     (w_cur_pot[30:23] != 8'hFF) && (w_cur_pot[30:23] <= 8'(w_cur_rate));

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            r_flush_count <= '0;
        else if (w_flush && r_flush_count != 16'hFFFF)
            r_flush_count <= r_flush_count + 16'd1;
    end

    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_potential_decay_array.sv
// Self-checking bench for potential_decay_array against a field-arithmetic reference model.
// Covers POTENTIAL_DECAY_FLUSH_COUNT_EN when the macro is defined for the build.
module tb_potential_decay_array;

    localparam int NUM_CH = 16;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        timestep;
    logic        busy;
    logic        sweep_done;
    logic        overrun;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rate_we;
    logic [3:0]  rate_addr;
    logic [2:0]  rate_data;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
    logic [15:0] flush_count;
`endif

    potential_decay_array #(.NUM_CH(NUM_CH), .ADDR_W(4), .RATE_W(3)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .timestep   (timestep),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rate_we    (rate_we),
        .rate_addr  (rate_addr),
        .rate_data  (rate_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
        ,
        .flush_count(flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pot  [NUM_CH];
    int          m_rate [NUM_CH];
    int          m_flush;
    logic [31:0] snap   [NUM_CH];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: divide by 2^r by lowering the biased exponent; non-positive result means zero.
    function automatic logic [31:0] m_decay(logic [31:0] x, int r);
        int e;
        int ne;
        e = int'(x[30:23]);
        if (r == 0 || e == 255) return x;
        ne = e - r;
        if (ne <= 0) return {x[31], 31'd0};
        return {x[31], ne[7:0], x[22:0]};
    endfunction

    task automatic m_sweep();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int e;
            e = int'(m_pot[ch][30:23]);
            if (m_rate[ch] != 0 && e != 0 && e != 255 && e <= m_rate[ch] && m_flush < 65535)
                m_flush++;
            m_pot[ch] = m_decay(m_pot[ch], m_rate[ch]);
        end
    endtask

    task automatic m_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_pot[ch]  = 32'd0;
            m_rate[ch] = 1;
        end
        m_flush = 0;
    endtask

    task automatic do_write(int a, logic [31:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        m_pot[a] = d;
    endtask

    task automatic do_rate(int a, int r);
        rate_we = 1'b1; rate_addr = 4'(a); rate_data = 3'(r);
        tick();
        rate_we = 1'b0;
        m_rate[a] = r;
    endtask

    task automatic read_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_addr = 4'(ch);
            tick();
            snap[ch] = rd_data;
        end
    endtask

    // Returns ticks from the sampling edge to the first sweep_done, or -1 on timeout.
    task automatic pulse_and_wait(output int done_at);
        done_at  = -1;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (sweep_done) begin
                done_at = n;
                break;
            end
        end
        tick();
    endtask

    function automatic logic [31:0] rand_float();
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else if (sel < 6)  e = 8'($urandom_range(1, 8));
        else               e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, sweep_done, overrun, wr_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 0001", {busy, sweep_done, overrun, wr_ready});
        end
        total++;
        if (rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_rd: got %h expected 00000000", rd_data);
        end
        RESET_N = 1'b1;
        m_reset();
        read_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            total++;
            if (snap[ch] !== 32'd0) begin
                bad++;
                $display("FAIL reset_pot[%0d]: got %h expected 00000000", ch, snap[ch]);
            end
        end
    endtask

    task automatic test_decay_basic();
        int d;
        do_rate(0, 1);
        do_write(0, 32'h41200000);
        pulse_and_wait(d);
        m_sweep();
        total++;
        if (d != NUM_CH) begin
            bad++;
            $display("FAIL basic_latency: got %0d expected %0d", d, NUM_CH);
        end
        read_all();
        total++;
        if (snap[0] !== 32'h40A00000) begin
            bad++;
            $display("FAIL basic_rate1: got %h expected 40a00000", snap[0]);
        end
        do_rate(0, 3);
        pulse_and_wait(d);
        m_sweep();
        read_all();
        total++;
        if (snap[0] !== 32'h3F200000) begin
            bad++;
            $display("FAIL basic_rate3: got %h expected 3f200000", snap[0]);
        end
    endtask

    task automatic test_special();
        int d;
        logic [31:0] exp_v [4];
        exp_v = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h3F800000};
        do_write(1, 32'h00800000);
        do_write(2, 32'h80800000);
        do_write(3, 32'h7F800000);
        do_write(4, 32'h3F800000);
        do_rate(4, 0);
        pulse_and_wait(d);
        m_sweep();
        read_all();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (snap[i+1] !== exp_v[i] || snap[i+1] !== m_pot[i+1]) begin
                bad++;
                $display("FAIL special_ch%0d: got %h expected %h", i + 1, snap[i+1], exp_v[i]);
            end
        end
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
        total++;
        if (flush_count !== 16'd2 || int'(flush_count) != m_flush) begin
            bad++;
            $display("FAIL special_flush_count: got %0d expected 2", flush_count);
        end
`endif
    endtask

    task automatic test_busy_write();
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        total++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_start: got busy=%b wr_ready=%b expected busy=1 wr_ready=0", busy, wr_ready);
        end
        for (int n = 1; n <= 17; n++) begin
            if (n == 3) begin
                total++;
                if (wr_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_wr_ready: got %b expected 0", wr_ready);
                end
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h40000000;
            end
            tick();
            wr_en = 1'b0;
            total++;
            if (sweep_done !== (n == 16) || busy !== (n <= 16)) begin
                bad++;
                $display("FAIL busy_timing n=%0d: got done=%b busy=%b expected done=%b busy=%b",
                         n, sweep_done, busy, n == 16, n <= 16);
            end
        end
        m_sweep();
        read_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            total++;
            if (snap[ch] !== m_pot[ch]) begin
                bad++;
                $display("FAIL busy_pot[%0d]: got %h expected %h", ch, snap[ch], m_pot[ch]);
            end
        end
    endtask

    task automatic test_pending();
        int dones;
        int first_at;
        int second_at;
        dones = 0; first_at = -1; second_at = -1;
        timestep = 1'b1;
        tick();
        for (int n = 1; n <= 60; n++) begin
            timestep = (n == 3 || n == 5);
            tick();
            if (sweep_done) begin
                dones++;
                if (first_at < 0) first_at = n;
                else second_at = n;
            end
        end
        timestep = 1'b0;
        m_sweep();
        m_sweep();
        total++;
        if (dones != 2 || first_at != 16 || second_at != 34) begin
            bad++;
            $display("FAIL pending_dones: got count=%0d at %0d,%0d expected count=2 at 16,34",
                     dones, first_at, second_at);
        end
        total++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pending_overrun: got overrun=%b busy=%b expected overrun=1 busy=0", overrun, busy);
        end
        read_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            total++;
            if (snap[ch] !== m_pot[ch]) begin
                bad++;
                $display("FAIL pending_pot[%0d]: got %h expected %h", ch, snap[ch], m_pot[ch]);
            end
        end
    endtask

    task automatic test_write_with_timestep();
        int d;
        d = -1;
        do_rate(5, 2);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h41000000; timestep = 1'b1;
        tick();
        wr_en = 1'b0; timestep = 1'b0;
        m_pot[5] = 32'h41000000;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (sweep_done) begin
                d = n;
                break;
            end
        end
        tick();
        m_sweep();
        total++;
        if (d != NUM_CH) begin
            bad++;
            $display("FAIL wr_ts_latency: got %0d expected %0d", d, NUM_CH);
        end
        read_all();
        total++;
        if (snap[5] !== 32'h40000000 || snap[5] !== m_pot[5]) begin
            bad++;
            $display("FAIL wr_ts_ch5: got %h expected 40000000", snap[5]);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            int k;
            int c;
            int nr;
            int d;
            for (int ch = 0; ch < NUM_CH; ch++) do_write(ch, rand_float());
            for (int i = 0; i < 4; i++) do_rate($urandom_range(0, NUM_CH - 1), $urandom_range(0, 7));
            k  = $urandom_range(1, 14);
            c  = $urandom_range(0, NUM_CH - 1);
            nr = $urandom_range(0, 7);
            d  = -1;
            timestep = 1'b1;
            tick();
            timestep = 1'b0;
            for (int n = 1; n <= 40; n++) begin
                if (n == k) begin
                    rate_we = 1'b1; rate_addr = 4'(c); rate_data = 3'(nr);
                end
                tick();
                rate_we = 1'b0;
                if (sweep_done) begin
                    d = n;
                    break;
                end
            end
            tick();
            // Channel k-1 is processed on the same edge the rate write lands, so it keeps the old rate.
            if (c >= k) begin
                m_rate[c] = nr;
                m_sweep();
            end else begin
                m_sweep();
                m_rate[c] = nr;
            end
            total++;
            if (d != NUM_CH) begin
                bad++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", round, d, NUM_CH);
            end
            read_all();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                total++;
                if (snap[ch] !== m_pot[ch]) begin
                    bad++;
                    $display("FAIL rand%0d_pot[%0d]: got %h expected %h", round, ch, snap[ch], m_pot[ch]);
                end
            end
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
            total++;
            if (int'(flush_count) != m_flush) begin
                bad++;
                $display("FAIL rand%0d_flush_count: got %0d expected %0d", round, flush_count, m_flush);
            end
`endif
        end
    endtask

    task automatic test_reset_midsweep();
        int dones;
        dones = 0;
        for (int ch = 0; ch < NUM_CH; ch++) do_write(ch, 32'h3F800000 + 32'(ch));
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (int n = 1; n <= 7; n++) tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        m_reset();
        total++;
        if ({busy, sweep_done, overrun, wr_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL midreset_flags: got %b expected 0001", {busy, sweep_done, overrun, wr_ready});
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            if (sweep_done) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL midreset_done: got %0d pulses expected 0", dones);
        end
        read_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            total++;
            if (snap[ch] !== m_pot[ch]) begin
                bad++;
                $display("FAIL midreset_pot[%0d]: got %h expected %h", ch, snap[ch], m_pot[ch]);
            end
        end
`ifdef POTENTIAL_DECAY_FLUSH_COUNT_EN
        total++;
        if (flush_count !== 16'd0) begin
            bad++;
            $display("FAIL midreset_flush_count: got %0d expected 0", flush_count);
        end
`endif
    endtask

    initial begin
        RESET_N   = 1'b0;
        timestep  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rate_we   = 1'b0;
        rate_addr = '0;
        rate_data = '0;
        rd_addr   = '0;
        m_reset();
        test_reset();
        test_decay_basic();
        test_special();
        test_busy_write();
        test_pending();
        test_write_with_timestep();
        test_random();
        test_reset_midsweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/potential_decay_array.md
Name: potential_decay_array

Overview:
Multi-channel, time-multiplexed membrane-potential decay engine for the neuron core.
- Holds NUM_CH IEEE-754 single-precision potentials in an internal register file.
- On each timestep pulse, sweeps all channels, one per cycle.
- Each channel is divided by 2^rate, using its own programmable rate, via exponent arithmetic.
- Successor to the single-channel fixed-rate decay unit; adds per-channel rates, load/read ports, sweep handshake and overrun detection.

Parameters:
NUM_CH, 16, number of neuron channels (>=2)
ADDR_W, 4, channel address width; must satisfy 2^ADDR_W >= NUM_CH
RATE_W, 3, width of per-channel decay rate

Ports:
CLK        input   1       clock, all logic on rising edge
RESET_N    input   1       synchronous active-low reset
timestep   input   1       single-cycle pulse, requests one decay sweep
busy       output  1       high while state is SWEEP or DONE
sweep_done output  1       one-cycle pulse when a sweep completes
overrun    output  1       sticky; a timestep was dropped
wr_en      input   1       potential write strobe
wr_addr    input   ADDR_W  potential write channel
wr_data    input   32      potential write value (float32)
wr_ready   output  1       high only in IDLE; writes accepted only then
rate_we    input   1       rate write strobe
rate_addr  input   ADDR_W  rate write channel
rate_data  input   RATE_W  decay rate; 0 disables decay for that channel
rd_addr    input   ADDR_W  read channel
rd_data    output  32      registered potential read

Behaviour:
- Reset (RESET_N low at a rising edge):
  - All potentials 0x00000000; all rates 1.
  - State IDLE; busy 0, sweep_done 0, overrun 0, rd_data 0, pending 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- States:
  - IDLE: on timestep or pending, clear pending and go to SWEEP with idx=0.
  - SWEEP: update channel idx, then idx++. When idx==NUM_CH-1, go to DONE.
  - DONE: sweep_done=1 for this cycle, then go to IDLE.
- Latency: timestep sampled at edge t gives channel k updated at edge t+1+k and sweep_done high during cycle t+NUM_CH+1.
- Timestep arriving while busy:
  - Sets pending (one deep). A pending sweep starts from IDLE on the cycle after DONE.
  - If pending is already set, the pulse is dropped and overrun is set; overrun clears only on reset.
- Decay op on x = {s, e[7:0], m[22:0]} with rate r:
  - r==0 -> unchanged.
  - e==255 (Inf/NaN) -> unchanged.
  - e==0 (zero/denormal) -> {s, 31'b0}.
  - e<=r -> {s, 31'b0} (flush to zero; denormals never produced).
  - Otherwise -> {s, e-r, m}.
- Writes:
  - wr_en with wr_ready=0 is ignored, with no side effects.
  - wr_en and timestep in the same IDLE cycle: the write lands first, and the sweep decays the written value.
  - Out-of-range addresses (>=NUM_CH) are ignored for writes; reads return 0.
- Rate writes are accepted in any state. A rate change mid-sweep applies only to channels not yet processed.
- Read: rd_data at edge t+1 reflects storage before edge t+1 updates (read-old on same-cycle write or decay).

Optional Feature:
Macro POTENTIAL_DECAY_FLUSH_COUNT_EN.
- Defined:
  - Adds output flush_count[15:0], reset to 0.
  - Increments once per channel whose decay op produced a flush to zero from a nonzero normal input.
  - Saturates at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load ch0 = 0x41200000 (10.0) with rate 1, pulse timestep -> after sweep_done, rd ch0 = 0x40A00000 (5.0). Set rate 3, sweep again -> 0x3F200000 (0.625).
- Load ch1=0x00800000, ch2=0x80800000, ch3=0x7F800000, ch4=0x3F800000 with rate 0 on ch4; sweep at rate 1 -> ch1=0x00000000, ch2=0x80000000, ch3=0x7F800000, ch4=0x3F800000; flush_count=2 (macro on).
- NUM_CH=16, timestep at edge t -> busy from t, sweep_done only in cycle t+17; wr_en with 0x40000000 during busy -> storage unchanged, wr_ready=0.
- Timestep pulses at t, t+3, t+5 -> second sweep starts right after first DONE; third pulse dropped; overrun=1; exactly two sweep_done pulses.
- wr_en ch5=0x41000000 (8.0) and timestep in the same cycle at rate 2 -> ch5 ends at 0x40000000 (2.0).
- RESET_N low at SWEEP idx=7 -> next cycle all potentials 0, busy 0, overrun 0, no sweep_done.
